// File: rtl/secuenciador_melodia_pkg.sv
// Shared definitions for the melody sequencer: state encoding, ROM entry
// layout and helpers that slice an entry into its frequency and duration fields.
package secuenciador_melodia_pkg;

    localparam int FREQ_W  = 16;
    localparam int DUR_W   = 8;
    localparam int ENTRY_W = FREQ_W + DUR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLAY  = 2'd2,
        GAP   = 2'd3
    } state_t;

    function automatic logic [FREQ_W-1:0] entry_freq(input logic [ENTRY_W-1:0] entry);
        return entry[ENTRY_W-1:DUR_W];
    endfunction

    function automatic logic [DUR_W-1:0] entry_dur(input logic [ENTRY_W-1:0] entry);
        return entry[DUR_W-1:0];
    endfunction

endpackage

// File: rtl/secuenciador_melodia_rom.sv
// Note table ROM. The image is a packed parameter with entry 0 in the least
// significant bits; each entry is {freq_hz, dur}. Read data is registered,
// so data follows addr with one cycle of latency.
module secuenciador_melodia_rom
    import secuenciador_melodia_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter logic [(2**ADDR_W)*ENTRY_W-1:0] ROM_INIT = '0
) (
    input  logic               clk,
    input  logic [ADDR_W-1:0]  addr,
    output logic [ENTRY_W-1:0] data
);

    // Synchronous table lookup
    always_ff @(posedge clk) begin
        data <= ROM_INIT[int'(addr)*ENTRY_W +: ENTRY_W];
    end

endmodule

// File: rtl/secuenciador_melodia.sv
// Melody sequencer: walks the note table, holds each note for dur ticks,
// inserts a silent gap after every note and drives the signed frequency
// word for the frequency divider. Supports stop, pause and looping.
module secuenciador_melodia
    import secuenciador_melodia_pkg::*;
#(
    parameter int TICK_CYCLES = 250_000,
    parameter int GAP_TICKS   = 2,
    parameter int ADDR_W      = 6,
    parameter logic [(2**ADDR_W)*ENTRY_W-1:0] ROM_INIT = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               play,
    input  logic               stop,
    input  logic               pause,
    input  logic               loop_en,
    output logic signed [31:0] freq,
    output logic [ADDR_W-1:0]  note_idx,
    output logic               busy,
    output logic               done
);

    localparam int                 CYC_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CYC_W-1:0]   CYC_LAST = CYC_W'(TICK_CYCLES - 1);
    localparam bit                 HAS_GAP  = (GAP_TICKS > 0);
    localparam logic [DUR_W-1:0]   GAP_LAST = HAS_GAP ? DUR_W'(GAP_TICKS - 1) : '0;

    state_t              state, state_n;
    logic [ADDR_W-1:0]   addr, addr_n;
    logic                fetch_rdy, fetch_rdy_n;
    logic [CYC_W-1:0]    cyc_cnt, cyc_n;
    logic [DUR_W-1:0]    tick_cnt, tick_n;
    logic [DUR_W-1:0]    dur_reg, dur_n;
    logic [FREQ_W-1:0]   freq_hold, freq_hold_n;
    logic signed [31:0]  freq_n;
    logic [ADDR_W-1:0]   idx_n;
    logic                busy_n, done_n;
    logic [ENTRY_W-1:0]  rom_data;
    logic [FREQ_W-1:0]   rom_freq;
    logic [DUR_W-1:0]    rom_dur;

    secuenciador_melodia_rom #(
        .ADDR_W   (ADDR_W),
        .ROM_INIT (ROM_INIT)
    ) u_rom (
        .clk  (clk),
        .addr (addr),
        .data (rom_data)
    );

    assign rom_freq = entry_freq(rom_data);
    assign rom_dur  = entry_dur(rom_data);

    // Next-state and next-output logic; outputs are computed here and registered below
    always_comb begin
        state_n     = state;
        addr_n      = addr;
        fetch_rdy_n = fetch_rdy;
        cyc_n       = cyc_cnt;
        tick_n      = tick_cnt;
        dur_n       = dur_reg;
        freq_hold_n = freq_hold;
        idx_n       = note_idx;
        done_n      = 1'b0;

        case (state)
            IDLE: begin
                if (play) begin
                    addr_n      = '0;
                    fetch_rdy_n = 1'b0;
                    state_n     = FETCH;
                end
            end
            FETCH: begin
                // First FETCH cycle lets the ROM register the entry for addr
                if (!fetch_rdy) begin
                    fetch_rdy_n = 1'b1;
                end else if (rom_dur != '0) begin
                    freq_hold_n = rom_freq;
                    dur_n       = rom_dur;
                    idx_n       = addr;
                    cyc_n       = '0;
                    tick_n      = '0;
                    state_n     = PLAY;
                end else if (loop_en) begin
                    addr_n      = '0;
                    fetch_rdy_n = 1'b0;
                end else begin
                    done_n      = 1'b1;
                    state_n     = IDLE;
                end
            end
            PLAY: begin
                if (!pause) begin
                    if (cyc_cnt == CYC_LAST) begin
                        cyc_n = '0;
                        if (tick_cnt == dur_reg - 1'b1) begin
                            tick_n = '0;
                            if (HAS_GAP) begin
                                state_n = GAP;
                            end else begin
                                addr_n      = addr + 1'b1;
                                fetch_rdy_n = 1'b0;
                                state_n     = FETCH;
                            end
                        end else begin
                            tick_n = tick_cnt + 1'b1;
                        end
                    end else begin
                        cyc_n = cyc_cnt + 1'b1;
                    end
                end
            end
            GAP: begin
                if (!pause) begin
                    if (cyc_cnt == CYC_LAST) begin
                        cyc_n = '0;
                        if (tick_cnt == GAP_LAST) begin
                            tick_n      = '0;
                            addr_n      = addr + 1'b1;
                            fetch_rdy_n = 1'b0;
                            state_n     = FETCH;
                        end else begin
                            tick_n = tick_cnt + 1'b1;
                        end
                    end else begin
                        cyc_n = cyc_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Stop aborts from anywhere, beats a simultaneous play and never pulses done
        if (stop) begin
            state_n     = IDLE;
            fetch_rdy_n = 1'b0;
            cyc_n       = '0;
            tick_n      = '0;
            done_n      = 1'b0;
        end

        busy_n = (state_n != IDLE);
        freq_n = (state_n == PLAY && !pause)
               ? $signed({{(32-FREQ_W){1'b0}}, freq_hold_n})
               : 32'sd0;
    end

    // State, counters and registered outputs with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            addr      <= '0;
            fetch_rdy <= 1'b0;
            cyc_cnt   <= '0;
            tick_cnt  <= '0;
            dur_reg   <= '0;
            freq_hold <= '0;
            freq      <= '0;
            note_idx  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            addr      <= addr_n;
            fetch_rdy <= fetch_rdy_n;
            cyc_cnt   <= cyc_n;
            tick_cnt  <= tick_n;
            dur_reg   <= dur_n;
            freq_hold <= freq_hold_n;
            freq      <= freq_n;
            note_idx  <= idx_n;
            busy      <= busy_n;
            done      <= done_n;
        end
    end

endmodule
